// File: rtl/branch_cond_unit.sv
// branch_cond_unit: per-context condition flags, 16-way condition evaluation,
// registered PC redirect and a fixed-length pipeline flush after a taken branch.
// Optional feature: define BRANCH_STATS_EN to build the saturating
// accepted/taken branch counters; otherwise br_total/br_taken read zero.
module branch_cond_unit #(
  parameter int unsigned NCTX         = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned CTX_W        = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_we,
  input  logic [CTX_W-1:0]  flag_ctx,
  input  logic [3:0]        flags_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [CTX_W-1:0]  br_ctx,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              pc_select,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush,
  output logic [CNT_W-1:0]  br_total,
  output logic [CNT_W-1:0]  br_taken
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_FLUSH = 1'b1;

  logic [3:0]        flags_q [NCTX];
  logic [3:0]        flags_d [NCTX];
  logic              state_q, state_d;
  logic [FC_W-1:0]   cnt_q, cnt_d;
  logic              br_ready_q, br_ready_d;
  logic              pc_select_q, pc_select_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic              flush_q, flush_d;

  logic [3:0] sel_flags;
  logic       ctx_ok;
  logic       fn, fz, fc, fv;
  logic       cond_raw;
  logic       accept;
  logic       taken;

  // Flag file update; out-of-range contexts match no entry and are dropped
  always_comb begin
    for (int unsigned i = 0; i < NCTX; i++) begin
      flags_d[i] = flags_q[i];
      if (flag_we && (flag_ctx == CTX_W'(i))) flags_d[i] = flags_in;
    end
  end

  // Select branch flags, bypassing a same-cycle write to the same context
  always_comb begin
    sel_flags = '0;
    ctx_ok    = 1'b0;
    for (int unsigned i = 0; i < NCTX; i++) begin
      if (br_ctx == CTX_W'(i)) begin
        ctx_ok    = 1'b1;
        sel_flags = (flag_we && (flag_ctx == br_ctx)) ? flags_in : flags_q[i];
      end
    end
  end

  // Condition code evaluation against {n, z, c, v}
  always_comb begin
    fn       = sel_flags[3];
    fz       = sel_flags[2];
    fc       = sel_flags[1];
    fv       = sel_flags[0];
    cond_raw = 1'b0;
    case (br_cond)
      4'd0:  cond_raw = fz;
      4'd1:  cond_raw = ~fz;
      4'd2:  cond_raw = fn ^ fv;
      4'd3:  cond_raw = ~(fn ^ fv);
      4'd4:  cond_raw = ~fz & ~(fn ^ fv);
      4'd5:  cond_raw = fz | (fn ^ fv);
      4'd6:  cond_raw = fc;
      4'd7:  cond_raw = ~fc;
      4'd8:  cond_raw = fn;
      4'd9:  cond_raw = ~fn;
      4'd10: cond_raw = fv;
      4'd11: cond_raw = ~fv;
      4'd12: cond_raw = fc & ~fz;
      4'd13: cond_raw = ~fc | fz;
      4'd14: cond_raw = 1'b1;
      4'd15: cond_raw = 1'b0;
    endcase
    accept = br_valid && br_ready_q && (state_q == S_IDLE);
    taken  = accept && ctx_ok && cond_raw;
  end

  // Redirect/flush FSM next-state and registered output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_select_d = 1'b0;
    pc_target_d = pc_target_q;
    flush_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (taken) begin
          state_d     = S_FLUSH;
          cnt_d       = FC_W'(FLUSH_CYCLES - 1);
          pc_select_d = 1'b1;
          pc_target_d = br_target;
          flush_d     = 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - FC_W'(1);
          flush_d = 1'b1;
        end
      end
    endcase
    br_ready_d = (state_d == S_IDLE);
  end

  // State, flag file and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCTX; i++) flags_q[i] <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      br_ready_q  <= 1'b0;
      pc_select_q <= 1'b0;
      pc_target_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCTX; i++) flags_q[i] <= flags_d[i];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      br_ready_q  <= br_ready_d;
      pc_select_q <= pc_select_d;
      pc_target_q <= pc_target_d;
      flush_q     <= flush_d;
    end
  end

  assign br_ready  = br_ready_q;
  assign pc_select = pc_select_q;
  assign pc_target = pc_target_q;
  assign flush     = flush_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_total_q, br_total_d;
  logic [CNT_W-1:0] br_taken_q, br_taken_d;

  // Saturating accepted/taken counters
  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (accept && (br_total_q != '1)) br_total_d = br_total_q + CNT_W'(1);
    if (taken && (br_taken_q != '1))  br_taken_d = br_taken_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`else
  assign br_total = '0;
  assign br_taken = '0;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit (NCTX=4, CTX_W=3, FLUSH_CYCLES=2,
// CNT_W=4) against a cycle-level behavioural model.
module tb_branch_cond_unit;

  localparam int NCTX = 4;
  localparam int FC   = 2;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        flag_we;
  logic [2:0]  flag_ctx;
  logic [3:0]  flags_in;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_ctx;
  logic [3:0]  br_cond;
  logic [31:0] br_target;
  logic        pc_select;
  logic [31:0] pc_target;
  logic        flush;
  logic [3:0]  br_total;
  logic [3:0]  br_taken;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model state
  bit [3:0]    m_flags [NCTX];
  int          m_left;
  bit          m_psel, m_flush, m_ready;
  logic [31:0] m_tgt;
  int          m_total, m_taken;

  branch_cond_unit #(
    .NCTX(4), .ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(4), .CTX_W(3)
  ) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .flag_ctx(flag_ctx),
    .flags_in(flags_in), .br_valid(br_valid), .br_ready(br_ready),
    .br_ctx(br_ctx), .br_cond(br_cond), .br_target(br_target),
    .pc_select(pc_select), .pc_target(pc_target), .flush(flush),
    .br_total(br_total), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  // Conditions come in complementary pairs: even code = base predicate, odd = its negation
  function automatic bit m_cond(input int code, input bit [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code / 2)
      0: base = z;
      1: base = (n != v);
      2: base = !z && (n == v);
      3: base = c;
      4: base = n;
      5: base = v;
      6: base = c && !z;
      default: base = 1'b1;
    endcase
    return (code % 2 == 0) ? base : !base;
  endfunction

  function automatic void model_edge();
    bit [3:0] f;
    bit acc, tk;
    if (!reset) begin
      for (int i = 0; i < NCTX; i++) m_flags[i] = 4'h0;
      m_left = 0; m_psel = 0; m_flush = 0; m_ready = 0; m_tgt = 32'h0;
      m_total = 0; m_taken = 0;
      return;
    end
    acc = br_valid && m_ready;
    f = (br_ctx < NCTX) ? m_flags[br_ctx[1:0]] : 4'h0;
    if (flag_we && flag_ctx == br_ctx) f = flags_in;
    tk = acc && (br_ctx < NCTX) && m_cond(int'(br_cond), f);
    m_psel = 0;
    if (m_left > 0) m_left--;
    else if (tk) begin m_left = FC; m_psel = 1; m_tgt = br_target; end
    m_flush = (m_left > 0);
    m_ready = (m_left == 0);
    if (flag_we && flag_ctx < NCTX) m_flags[flag_ctx[1:0]] = flags_in;
`ifdef BRANCH_STATS_EN
    if (acc && m_total < CMAX) m_total++;
    if (tk && m_taken < CMAX) m_taken++;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    flag_we = 0; flag_ctx = 0; flags_in = 0;
    br_valid = 0; br_ctx = 0; br_cond = 0; br_target = 0;
  endtask

  task automatic settle();
    clear_inputs();
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    cyc(); cyc();
    n_vec++;
    if ({pc_select, flush, br_ready, pc_target, br_total, br_taken} !== 43'h0) begin
      n_bad++;
      $display("FAIL reset_state: got sel=%b fl=%b rdy=%b tgt=%h tot=%0d tkn=%0d exp all 0",
               pc_select, flush, br_ready, pc_target, br_total, br_taken);
    end
    reset = 1;
    cyc();
    n_vec++;
    if (br_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b exp 1", br_ready);
    end
  endtask

  task automatic test_ge();
    flag_we = 1; flag_ctx = 0; flags_in = 4'b1001;
    cyc();
    clear_inputs();
    br_valid = 1; br_ctx = 0; br_cond = 4'd3; br_target = 32'h100;
    cyc();
    clear_inputs();
    n_vec++;
    if ({pc_select, flush, br_ready, pc_target} !== {3'b110, 32'h100}) begin
      n_bad++;
      $display("FAIL ge_redirect: got sel=%b fl=%b rdy=%b tgt=%h exp sel=1 fl=1 rdy=0 tgt=100",
               pc_select, flush, br_ready, pc_target);
    end
    cyc();
    n_vec++;
    if ({pc_select, flush, br_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL ge_flush2: got sel=%b fl=%b rdy=%b exp 0 1 0", pc_select, flush, br_ready);
    end
    cyc();
    n_vec++;
    if ({pc_select, flush, br_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL ge_end: got sel=%b fl=%b rdy=%b exp 0 0 1", pc_select, flush, br_ready);
    end
  endtask

  task automatic test_bypass();
    flag_we = 1; flag_ctx = 1; flags_in = 4'h0; cyc();
    flag_ctx = 0; cyc();
    flag_we = 1; flag_ctx = 1; flags_in = 4'b0100;
    br_valid = 1; br_ctx = 1; br_cond = 4'd0; br_target = 32'h200;
    cyc();
    clear_inputs();
    n_vec++;
    if ({pc_select, pc_target} !== {1'b1, 32'h200}) begin
      n_bad++;
      $display("FAIL bypass_taken: got sel=%b tgt=%h exp sel=1 tgt=200", pc_select, pc_target);
    end
    cyc(); cyc();
    flag_we = 1; flag_ctx = 1; flags_in = 4'b0100;
    br_valid = 1; br_ctx = 0; br_cond = 4'd0; br_target = 32'h300;
    cyc();
    clear_inputs();
    n_vec++;
    if ({pc_select, flush} !== 2'b00) begin
      n_bad++;
      $display("FAIL bypass_other_ctx: got sel=%b fl=%b exp 0 0", pc_select, flush);
    end
  endtask

  task automatic test_back_to_back();
    int sel_cnt = 0;
    br_valid = 1; br_ctx = 0; br_cond = 4'd14;
    for (int k = 0; k < 9; k++) begin
      br_target = $urandom;
      cyc();
      if (pc_select) sel_cnt++;
      n_vec++;
      if ({pc_select, flush, br_ready, pc_target} !== {m_psel, m_flush, m_ready, m_tgt}) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: got sel=%b fl=%b rdy=%b tgt=%h exp %b %b %b %h",
                 k, pc_select, flush, br_ready, pc_target, m_psel, m_flush, m_ready, m_tgt);
      end
    end
    clear_inputs();
    n_vec++;
    if (sel_cnt != 3) begin
      n_bad++;
      $display("FAIL b2b_accepts: got %0d exp 3", sel_cnt);
    end
    settle();
  endtask

  task automatic test_sweep();
    for (int cd = 0; cd < 16; cd++) begin
      for (int fv = 0; fv < 16; fv++) begin
        flag_we = 1; flag_ctx = 3; flags_in = 4'(fv);
        cyc();
        clear_inputs();
        br_valid = 1; br_ctx = 3; br_cond = 4'(cd); br_target = $urandom;
        cyc();
        clear_inputs();
        n_vec++;
        if (pc_select !== m_cond(cd, 4'(fv)) || (cd == 15 && pc_select !== 1'b0)) begin
          n_bad++;
          $display("FAIL sweep_c%0d_f%0h: got sel=%b exp %b", cd, fv, pc_select, m_cond(cd, 4'(fv)));
        end
        cyc(); cyc();
      end
    end
    for (int fv = 0; fv < 16; fv++) begin
      flag_we = 1; flag_ctx = 5; flags_in = 4'(fv);
      br_valid = 1; br_ctx = 5; br_cond = 4'd14; br_target = $urandom;
      cyc();
      clear_inputs();
      n_vec++;
      if (pc_select !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_ctx_f%0h: got sel=%b exp 0", fv, pc_select);
      end
      cyc(); cyc();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      reset     = ($urandom_range(0, 49) != 0);
      flag_we   = $urandom_range(0, 1);
      flag_ctx  = 3'($urandom_range(0, 7));
      flags_in  = 4'($urandom);
      br_valid  = ($urandom_range(0, 2) != 0);
      br_ctx    = 3'($urandom_range(0, 4));
      br_cond   = 4'($urandom);
      br_target = $urandom;
      cyc();
      n_vec++;
      if ({pc_select, flush, br_ready, pc_target, br_total, br_taken} !==
          {m_psel, m_flush, m_ready, m_tgt, 4'(m_total), 4'(m_taken)}) begin
        n_bad++;
        $display("FAIL random_%0d: got sel=%b fl=%b rdy=%b tgt=%h tot=%0d tkn=%0d exp %b %b %b %h %0d %0d",
                 k, pc_select, flush, br_ready, pc_target, br_total, br_taken,
                 m_psel, m_flush, m_ready, m_tgt, m_total, m_taken);
      end
    end
    reset = 1;
    settle();
  endtask

  task automatic test_stats();
    int exp_cnt;
`ifdef BRANCH_STATS_EN
    exp_cnt = 15;
`else
    exp_cnt = 0;
`endif
    clear_inputs();
    reset = 0; cyc();
    reset = 1; cyc();
    br_valid = 1; br_ctx = 0; br_cond = 4'd14; br_target = 32'hABC;
    repeat (60) cyc();
    clear_inputs();
    cyc();
    n_vec++;
    if (int'(br_total) != exp_cnt || int'(br_taken) != exp_cnt) begin
      n_bad++;
      $display("FAIL stats_sat: got tot=%0d tkn=%0d exp %0d %0d", br_total, br_taken, exp_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    flag_we = 1; flag_ctx = 0; flags_in = 4'b0100; cyc();
    clear_inputs();
    br_valid = 1; br_cond = 4'd14; br_target = 32'h55;
    cyc();
    clear_inputs();
    n_vec++;
    if ({pc_select, flush} !== 2'b11) begin
      n_bad++;
      $display("FAIL midflush_start: got sel=%b fl=%b exp 1 1", pc_select, flush);
    end
    reset = 0; cyc(); cyc();
    n_vec++;
    if ({pc_select, flush, br_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL midflush_reset: got sel=%b fl=%b rdy=%b exp 0 0 0", pc_select, flush, br_ready);
    end
    reset = 1; cyc();
    n_vec++;
    if (br_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midflush_ready: got %b exp 1", br_ready);
    end
    br_valid = 1; br_ctx = 0; br_cond = 4'd0; br_target = 32'h77;
    cyc();
    clear_inputs();
    n_vec++;
    if ({pc_select, flush} !== 2'b00) begin
      n_bad++;
      $display("FAIL midflush_flags_cleared: got sel=%b fl=%b exp 0 0", pc_select, flush);
    end
  endtask

  initial begin
    test_reset();
    test_ge();
    test_bypass();
    test_back_to_back();
    test_sweep();
    test_random();
    test_stats();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Parametrised branch-resolution unit for the execution stage: holds per-context condition flags, evaluates a 4-bit condition code against them, and issues a registered PC redirect plus a multi-cycle pipeline flush when a branch is taken. It generalises the 2-bit, single-flag-set branch check to NCTX flag contexts, 16 conditions, carry-flag support, same-cycle flag bypass and a flush/ready handshake. It sits between the ALU flag outputs and the fetch-stage PC mux.

## Interface
- NCTX, 2, number of independent flag contexts (≥1); CTX_W = max(1, $clog2(NCTX))
- ADDR_W, 32, branch target width
- FLUSH_CYCLES, 2, flush length in cycles (≥1)
- CNT_W, 16, statistics counter width
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- flag_we  input  1  write flags_in into context flag_ctx
- flag_ctx  input  CTX_W  context to write
- flags_in  input  4  {neg, zero, carry, overflow}
- br_valid  input  1  branch presented this cycle
- br_ready  output  1  unit accepts branch this cycle
- br_ctx  input  CTX_W  flag context used by branch
- br_cond  input  4  condition code
- br_target  input  ADDR_W  redirect address
- pc_select  output  1  one-cycle redirect strobe to PC mux
- pc_target  output  ADDR_W  redirect address, valid when pc_select=1
- flush  output  1  squash younger pipeline stages
- br_total  output  CNT_W  accepted branches (see Configuration)
- br_taken  output  CNT_W  taken branches (see Configuration)

## Operation
- Flag file: NCTX × 4-bit registers; written on flag_we regardless of FSM state. flag_ctx ≥ NCTX: write ignored.
- Bypass: if flag_we && br_valid && flag_ctx==br_ctx in the same cycle, branch evaluates flags_in, not stored flags.
- Conditions (n,z,c,v): 0 EQ z; 1 NE ~z; 2 LT n≠v; 3 GE n==v; 4 GT ~z&(n==v); 5 LE z|(n≠v); 6 CS c; 7 CC ~c; 8 MI n; 9 PL ~n; 10 VS v; 11 VC ~v; 12 HI c&~z; 13 LS ~c|z; 14 AL 1; 15 NV 0.
- Legacy 2-bit encodings map as: GTE→4, GE→3, EQ→0, Always→14 (decoder's responsibility).
- Accept = br_valid && br_ready. taken = accept && cond true. br_ctx ≥ NCTX: cond forced false.
- FSM: IDLE (br_ready=1) and FLUSH (br_ready=0).
  - IDLE, taken: next cycle pc_select=1, pc_target=latched br_target, flush=1, go FLUSH, down-counter loaded with FLUSH_CYCLES−1.
  - IDLE, not taken or no branch: stay IDLE, outputs 0.
  - FLUSH: flush=1; counter==0 → IDLE, else decrement. br_valid ignored (wrong-path).
- Reset: all flags 0, state IDLE, counter 0, pc_select=0, pc_target=0, flush=0, br_ready=0 during reset cycle then 1, counters 0. Reset mid-FLUSH aborts flush at the next edge.

## Timing
- Accept-to-pc_select latency: 1 cycle; pc_select high exactly 1 cycle per taken branch.
- flush high exactly FLUSH_CYCLES consecutive cycles, starting same cycle as pc_select.
- br_ready low for those same FLUSH_CYCLES cycles; next branch accepted the cycle flush falls.
- Flag write visible to stored-path evaluation the cycle after flag_we; same cycle via bypass.
- All outputs registered; no combinational path inputs→pc_select/flush. br_ready depends on state only.

## Configuration
- BRANCH_STATS_EN defined: br_total increments on every accept, br_taken on every taken; both saturate at 2^CNT_W−1; cleared by reset.
- Undefined: counters not built; br_total and br_taken tied to 0; ports remain present.

## Test plan
- Reset: hold reset=0 two cycles mid-FLUSH → pc_select=0, flush=0, flags=0, br_ready=1 one cycle after reset=1.
- Flag write ctx0 {n=1,z=0,c=0,v=1}, next cycle branch ctx0 cond GE(3), target 0x100 → pc_select=1, pc_target=0x100 one cycle later; flush high 2 cycles (FLUSH_CYCLES=2).
- Same-cycle flag_we ctx1 z=1 and branch ctx1 cond EQ(0), stored z=0 → taken via bypass; branch ctx0 EQ same flags unaffected → not taken.
- Branch presented every cycle, cond AL → accepted only every 3rd cycle (FLUSH_CYCLES=2); br_ready low 2 cycles each time.
- Sweep all 16 conds × 16 flag values on NCTX=4, ctx3 → taken matches table; cond 15 never taken; br_ctx=5 (NCTX=4, CTX_W=3) never taken.
- BRANCH_STATS_EN, CNT_W=4: 20 taken AL branches → br_total=br_taken=15 (saturated); without macro both read 0.
